gemm_layer_sched: RTL
=====================

Name: gemm_layer_sched

Overview:
Sequencer for the RL inference chain of GEMM layer engines. It loads one input vector, runs each layer in turn by holding that layer's gvalid high, feeds it serially, collects its serial outputs, and clears it by dropping gvalid. It then re-feeds those outputs to the next layer, ping-ponging between two internal buffers. After the last layer it streams the final vector out. Sits between the host/environment interface and the GEMM layer instances.

Parameters:
WIDTH, 16, data word width (fp16)
NL, 3, number of layers sequenced
D0, 16, input vector length
D1, 64, layer-0 output length
D2, 256, layer-1 output length
D3, 2, layer-2 output length (final result)
MAXD, 256, buffer depth; must be >= every Dn
GAP, 2, gvalid-low cycles between layers (layer clear)
TIMEOUT, 4095, max cycles waiting for one layer's outputs

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  begin a run (pulse); honoured only in IDLE/DONE/ERR
in_valid  in  1  input word strobe
in_data  in  WIDTH  input vector word
gvalid  out  NL  per-layer enable; one-hot or zero
lvalid  out  1  ivalid shared by all layers
ldata  out  WIDTH  serial data shared by all layers
lo_valid  in  NL  per-layer ovalid
lo_data  in  NL*WIDTH  per-layer out, layer l at [l*WIDTH +: WIDTH]
res_valid  out  1  final result word strobe
res_data  out  WIDTH  final result word
busy  out  1  high in any state other than IDLE/DONE/ERR
done  out  1  one-cycle pulse after the last res_valid
err  out  1  timeout flag; held until next accepted start
layer  out  clog2(NL)  index of active layer (debug)

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0; buffer contents undefined. Async reset mid-run drops gvalid to 0 immediately.
- Buffers: bufA, bufB, MAXD x WIDTH each; counters clog2(MAXD+1) bits. in_len(l) = D0 for l=0, else D(l). out_len(l) = D(l+1).
- IDLE: on start, go to LOAD next cycle, clear err, layer=0, write pointer=0.
- LOAD: each in_valid writes in_data to bufA[wp], wp++. After D0 words go to FEED. in_valid outside LOAD is ignored.
- FEED: gvalid[layer]=1 starting the cycle FEED is entered. Each cycle, lvalid=1 and ldata=src[rp], rp++ (registered outputs). After in_len words, lvalid=0 and go to WAIT with gvalid held.
- WAIT/FEED collect: each lo_valid[layer] writes lo_data slice to dst[oc], oc++. Collection is enabled from FEED entry, because outputs arriving during FEED count. lo_valid from non-active layers is ignored. Words beyond out_len are dropped. When oc==out_len, go to CLEAR. A watchdog counts WAIT cycles; when it reaches TIMEOUT, go to ERR.
- CLEAR: gvalid=0 for GAP cycles. Then, if layer==NL-1, go to DRAIN. Otherwise layer++, swap src/dst, rp=oc=0, and go to FEED. Layer 0 uses src=bufA, dst=bufB, and roles alternate per layer.
- DRAIN: res_valid=1 with dst words 0..D(NL)-1 on consecutive cycles, no back-pressure. Then done=1 for one cycle and go to DONE.
- DONE: busy=0. start behaves as in IDLE.
- ERR: gvalid=0, err=1, busy=0. Only start leaves ERR, going to LOAD.
- start while busy is ignored. start and in_valid in the same IDLE cycle: the word is not captured; loading begins the next cycle.
- No arithmetic on data; words pass through bit-exact.

Test Plan:
- Nominal (NL=3, D0=4, D1=3, D2=2, D3=2); input 1..4; layer models return fixed words after 5 cycles -> gvalid sequence 001,000x2,010,000x2,100,000x2; each layer's ldata equals the previous layer's outputs in order; res_data streamed; done pulses once.
- Early outputs: layer model emits the first output during FEED -> word captured, oc counts it, no loss.
- Stray and excess: lo_valid[2] asserted while layer 0 active, plus one extra layer-0 word -> both ignored, buffer unchanged.
- Timeout (TIMEOUT=20): layer 1 never responds -> ERR 20 cycles after WAIT entry, gvalid=0, err=1; a later start clears err and the run completes.
- start pulsed mid-FEED -> no effect; run finishes normally.
- rst asserted during layer-1 WAIT -> gvalid/lvalid/busy 0 in the same cycle; after release, a new run produces correct results.

Source files
------------

// File: rtl/gemm_layer_sched_if.sv
// Host and layer-bus signals of the GEMM layer scheduler.
// The master side is the scheduler; the slave side is the environment and the layer engines.
interface gemm_layer_sched_if #(
    parameter int WIDTH = 16,
    parameter int NL    = 3
);
    localparam int LW = (NL > 1) ? $clog2(NL) : 1;

    logic                start;
    logic                in_valid;
    logic [WIDTH-1:0]    in_data;
    logic [NL-1:0]       gvalid;
    logic                lvalid;
    logic [WIDTH-1:0]    ldata;
    logic [NL-1:0]       lo_valid;
    logic [NL*WIDTH-1:0] lo_data;
    logic                res_valid;
    logic [WIDTH-1:0]    res_data;
    logic                busy;
    logic                done;
    logic                err;
    logic [LW-1:0]       layer;

    modport master (
        input  start, in_valid, in_data, lo_valid, lo_data,
        output gvalid, lvalid, ldata, res_valid, res_data, busy, done, err, layer
    );

    modport slave (
        output start, in_valid, in_data, lo_valid, lo_data,
        input  gvalid, lvalid, ldata, res_valid, res_data, busy, done, err, layer
    );
endinterface

// File: rtl/gemm_layer_sched.sv
// Sequences one vector through NL serial GEMM layers, ping-ponging between two buffers,
// then streams the final layer's output vector.
module gemm_layer_sched #(
    parameter int WIDTH   = 16,
    parameter int NL      = 3,
    parameter int D0      = 16,
    parameter int D1      = 64,
    parameter int D2      = 256,
    parameter int D3      = 2,
    parameter int MAXD    = 256,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 4095
) (
    input  logic               clk,
    input  logic               rst,
    gemm_layer_sched_if.master bus
);
    localparam int LW   = (NL > 1) ? $clog2(NL) : 1;
    localparam int CW   = $clog2(MAXD + 1);
    localparam int AW   = (MAXD > 1) ? $clog2(MAXD) : 1;
    localparam int WW   = $clog2(TIMEOUT + 1);
    localparam int GW   = $clog2(GAP + 1);
    localparam int DFIN = (NL == 1) ? D1 : (NL == 2) ? D2 : D3;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_CLEAR = 3'd4;
    localparam logic [2:0] S_DRAIN = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;
    localparam logic [2:0] S_ERR   = 3'd7;

    function automatic logic [CW-1:0] in_len(input logic [LW-1:0] l);
        if (l == '0)            in_len = CW'(D0);
        else if (l == LW'(1))   in_len = CW'(D1);
        else                    in_len = CW'(D2);
    endfunction

    function automatic logic [CW-1:0] out_len(input logic [LW-1:0] l);
        if (l == '0)            out_len = CW'(D1);
        else if (l == LW'(1))   out_len = CW'(D2);
        else                    out_len = CW'(D3);
    endfunction

    function automatic logic [NL-1:0] onehot(input logic [LW-1:0] l);
        onehot    = '0;
        onehot[l] = 1'b1;
    endfunction

    logic [2:0]       state_q, state_d;
    logic [LW-1:0]    layer_q, layer_d;
    logic [CW-1:0]    wp_q, wp_d, rp_q, rp_d, oc_q, oc_d;
    logic [WW-1:0]    wd_q, wd_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [NL-1:0]    gvalid_q, gvalid_d;
    logic             lvalid_q, lvalid_d;
    logic [WIDTH-1:0] ldata_q, ldata_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] bufa_q [MAXD];
    logic [WIDTH-1:0] bufb_q [MAXD];

    // Even layers read bufA and write bufB; odd layers the reverse.
    logic             src_a;
    logic             cap, load_we, a_we, b_we;
    logic [AW-1:0]    a_addr;
    logic [WIDTH-1:0] a_wdata, lo_word, src_word, dst_word;
    logic [LW-1:0]    layer_nx;

    assign src_a    = ~layer_q[0];
    assign layer_nx = layer_q + 1'b1;
    assign lo_word  = bus.lo_data[layer_q*WIDTH +: WIDTH];
    assign cap      = (state_q == S_FEED || state_q == S_WAIT) && bus.lo_valid[layer_q]
                      && (oc_q < out_len(layer_q));
    assign load_we  = (state_q == S_LOAD) && bus.in_valid;
    assign a_we     = load_we | (cap & ~src_a);
    assign b_we     = cap & src_a;
    assign a_addr   = load_we ? wp_q[AW-1:0] : oc_q[AW-1:0];
    assign a_wdata  = load_we ? bus.in_data : lo_word;
    assign src_word = src_a ? bufa_q[rp_q[AW-1:0]] : bufb_q[rp_q[AW-1:0]];
    assign dst_word = src_a ? bufb_q[rp_q[AW-1:0]] : bufa_q[rp_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (a_we) bufa_q[a_addr] <= a_wdata;
        if (b_we) bufb_q[oc_q[AW-1:0]] <= lo_word;
    end

    always_comb begin
        state_d     = state_q;
        layer_d     = layer_q;
        wp_d        = wp_q;
        rp_d        = rp_q;
        oc_d        = cap ? oc_q + 1'b1 : oc_q;
        wd_d        = wd_q;
        gap_d       = gap_q;
        gvalid_d    = gvalid_q;
        lvalid_d    = 1'b0;
        ldata_d     = ldata_q;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        done_d      = 1'b0;
        err_d       = err_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.start) begin
                    state_d = S_LOAD;
                    err_d   = 1'b0;
                    layer_d = '0;
                    wp_d    = '0;
                end
            end
            S_LOAD: begin
                if (bus.in_valid) begin
                    wp_d = wp_q + 1'b1;
                    if (wp_q == CW'(D0 - 1)) begin
                        state_d  = S_FEED;
                        gvalid_d = onehot('0);
                        rp_d     = '0;
                        oc_d     = '0;
                    end
                end
            end
            S_FEED: begin
                if (rp_q == in_len(layer_q)) begin
                    state_d = S_WAIT;
                    wd_d    = '0;
                end else begin
                    lvalid_d = 1'b1;
                    ldata_d  = src_word;
                    rp_d     = rp_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (oc_q == out_len(layer_q)) begin
                    state_d  = S_CLEAR;
                    gvalid_d = '0;
                    gap_d    = '0;
                end else if (wd_q == WW'(TIMEOUT - 1)) begin
                    state_d  = S_ERR;
                    gvalid_d = '0;
                    err_d    = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_CLEAR: begin
                if (gap_q == GW'(GAP - 1)) begin
                    rp_d = '0;
                    if (layer_q == LW'(NL - 1)) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d  = S_FEED;
                        layer_d  = layer_nx;
                        gvalid_d = onehot(layer_nx);
                        oc_d     = '0;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (rp_q == CW'(DFIN)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    res_valid_d = 1'b1;
                    res_data_d  = dst_word;
                    rp_d        = rp_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            layer_q     <= '0;
            wp_q        <= '0;
            rp_q        <= '0;
            oc_q        <= '0;
            wd_q        <= '0;
            gap_q       <= '0;
            gvalid_q    <= '0;
            lvalid_q    <= 1'b0;
            ldata_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            layer_q     <= layer_d;
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            oc_q        <= oc_d;
            wd_q        <= wd_d;
            gap_q       <= gap_d;
            gvalid_q    <= gvalid_d;
            lvalid_q    <= lvalid_d;
            ldata_q     <= ldata_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.gvalid    = gvalid_q;
    assign bus.lvalid    = lvalid_q;
    assign bus.ldata     = ldata_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.layer     = layer_q;
    assign bus.busy      = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
endmodule
